ssp_rx_fifo: RTL and testbench
==============================

Name: ssp_rx_fifo

Overview:
Parametrised successor to the single-word SSP receiver. It deserialises TI-style SSP frames (FSS pulse, then DATA_W bits) from the external sspclkin/sspfssin/ssprxd pins into the clk_i domain. Received words are buffered in a first-word-fall-through FIFO. It adds selectable bit order, occupancy count, overrun detection and mid-word resynchronisation, and sits between the SSP pins and the bus-side register block.

Parameters:
DATA_W, 8, bits per frame; legal 4..16
FIFO_DEPTH, 4, words of receive buffering; power of 2, >=2
MSB_FIRST, 1, 1 = first bit received is word MSB; 0 = LSB

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous active-high reset
sspclkin  in  1  SSP serial clock, asynchronous to clk_i
sspfssin  in  1  SSP frame sync, high one sspclk period before first bit
ssprxd  in  1  SSP serial data
do_read  in  1  pop head word; one-cycle strobe
clr_ovr  in  1  clear rx_overrun
rx_d  out  DATA_W  FIFO head word, valid while rx_full=1
rx_full  out  1  FIFO non-empty (legacy name: word available)
rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
rx_overrun  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: rx_d=0, rx_full=0, rx_count=0, rx_overrun=0. FSM goes to IDLE and the bit counter clears. All three input synchronisers clear to 0. rst_i mid-frame discards the partial word.
- Input sync: sspclkin, sspfssin and ssprxd each pass through a 2-FF synchroniser. A third sspclkin register feeds edge detection.
- Sample strobe: the synchronised sspclkin falling edge (sync2=0, sync3=1). It is a one-clk_i-cycle pulse.
- Input constraint: each sspclkin phase must last >=2 clk_i periods. Behaviour is undefined otherwise.
- FSM state IDLE:
  - On a strobe with sspfssin_sync=1, go to SHIFT and set bit_cnt=0.
  - On any other strobe, stay in IDLE.
- FSM state SHIFT:
  - On each strobe, shift ssprxd_sync into the shift register and increment bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters the LSB. MSB_FIRST=0: shift right, new bit enters the MSB.
- Word completion (strobe with bit_cnt==DATA_W-1):
  - The completed word, including the current bit, is pushed at that clk_i edge.
  - If sspfssin_sync=1 on this same strobe, go back to SHIFT with bit_cnt=0 (back-to-back frames). Otherwise go to IDLE.
- Resync: a strobe with sspfssin_sync=1 in SHIFT and bit_cnt<DATA_W-1 discards the partial word, sets bit_cnt=0 and stays in SHIFT. No push occurs.
- Latency: a pushed word is visible on rx_d/rx_full/rx_count at the 3rd clk_i rising edge after the final sspclkin falling edge at the pin.
- FIFO read side:
  - First-word fall-through: rx_d always shows the head word.
  - do_read with rx_full=1 pops the head; the next word or empty state is visible the following cycle.
  - do_read with rx_full=0 is ignored.
- FIFO push/pop interactions:
  - Push while full with no pop: the word is dropped and rx_overrun=1; FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, rx_count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: push happens, pop is ignored, rx_count=1.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. rx_count is derived from pointers with one extra bit.
- rx_overrun: held until clr_ovr=1 or reset. If clr_ovr and a new overrun occur in the same cycle, the overrun wins (flag stays 1).

Optional Feature:
Macro SSP_RX_FRAME_ERR_EN.
- Defined: adds output rx_frame_err (1 bit). It is a sticky flag, set on every resync event, and also cleared by clr_ovr or reset.
- Undefined: port and logic are absent; resync still discards partial words silently.

Test Plan:
Clocks for all scenarios: clk_i 20 ns period, sspclkin 160 ns period. Base configuration: DATA_W=8, FIFO_DEPTH=4, MSB_FIRST=1.
1. Single frame 0xA5 -> rx_full=1, rx_d=0xA5, rx_count=1 at the 3rd clk_i edge after the 8th falling edge; one do_read -> rx_full=0, rx_count=0.
2. Back-to-back frames 0x01,0x02,0x03 with FSS overlapping each last bit, no reads -> rx_count=3; three do_read pulses return 0x01,0x02,0x03 in order; do_read on empty leaves rx_count=0.
3. Five frames 0x10..0x14 with no reads -> rx_count=4, rx_overrun=1; reads return 0x10..0x13; clr_ovr pulse -> rx_overrun=0.
4. FIFO full, do_read in the same cycle as the push of 0x55 -> rx_count stays 4, rx_overrun stays 0, 0x55 is read last.
5. FSS reasserted after 3 bits, then full frame 0x3C -> only 0x3C is stored, rx_count=1; with SSP_RX_FRAME_ERR_EN, rx_frame_err=1.
6. rst_i pulse after 4 bits of a frame, then frame 0xA5 with MSB_FIRST=0 sent LSB-first -> all outputs 0 during reset; afterwards rx_d=0xA5, rx_count=1.

Source files
------------

// File: rtl/ssp_rx_fifo.sv
// TI-style SSP frame receiver with a first-word-fall-through receive FIFO.
// Optional sticky resync flag on output rx_frame_err when SSP_RX_FRAME_ERR_EN is defined.
module ssp_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sspclkin,
  input  logic                          sspfssin,
  input  logic                          ssprxd,
  input  logic                          do_read,
  input  logic                          clr_ovr,
  output logic [DATA_W-1:0]             rx_d,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun
`ifdef SSP_RX_FRAME_ERR_EN
  ,
  output logic                          rx_frame_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    LAST_BIT = 4'(DATA_W - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic              fss_s1_q, fss_s2_q;
  logic              rxd_s1_q, rxd_s2_q;

  state_t            state_q;
  logic [3:0]        bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] word_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_s;
  logic              strobe_s, last_s, push_s, resync_s;
  logic              empty_s, full_s, pop_s, wr_en_s, ovr_set_s;
  logic              overrun_q;

  // Two-stage synchronisers on all pins, plus a third sspclkin stage for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      fss_s1_q  <= 1'b0;
      fss_s2_q  <= 1'b0;
      rxd_s1_q  <= 1'b0;
      rxd_s2_q  <= 1'b0;
    end else begin
      sclk_s1_q <= sspclkin;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      fss_s1_q  <= sspfssin;
      fss_s2_q  <= fss_s1_q;
      rxd_s1_q  <= ssprxd;
      rxd_s2_q  <= rxd_s1_q;
    end
  end

  assign strobe_s  = ~sclk_s2_q & sclk_s3_q;
  assign last_s    = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign push_s    = strobe_s && last_s;
  assign resync_s  = strobe_s && (state_q == SHIFT) && !last_s && fss_s2_q;

  // Shift register contents including the bit being sampled on this strobe.
  always_comb begin
    word_d = shift_q;
    if (MSB_FIRST != 0) begin
      word_d = {shift_q[DATA_W-2:0], rxd_s2_q};
    end else begin
      word_d = {rxd_s2_q, shift_q[DATA_W-1:1]};
    end
  end

  // Frame FSM: wait for FSS, then collect DATA_W bits; FSS inside a frame restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
    end else if (strobe_s) begin
      case (state_q)
        IDLE: begin
          if (fss_s2_q) begin
            state_q   <= SHIFT;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
          end else begin
            state_q   <= IDLE;
          end
        end
        SHIFT: begin
          if (last_s) begin
            state_q   <= fss_s2_q ? SHIFT : IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
          end else if (fss_s2_q) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
          end else begin
            shift_q   <= word_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= 4'd0;
          shift_q   <= '0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  assign count_s   = wr_ptr_q - rd_ptr_q;
  assign empty_s   = (count_s == {CW{1'b0}});
  assign full_s    = (count_s == DEPTH_C);
  assign pop_s     = do_read && !empty_s;
  assign wr_en_s   = push_s && (!full_s || pop_s);
  assign ovr_set_s = push_s && full_s && !pop_s;

  // FIFO storage and pointers; the pointer MSB distinguishes full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= word_d;
        wr_ptr_q                <= wr_ptr_q + CW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
      end
    end
  end

  // Sticky overrun; a new drop in the same cycle beats the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_q <= 1'b1;
    end else if (clr_ovr) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q;
    end
  end

`ifdef SSP_RX_FRAME_ERR_EN
  logic frame_err_q;

  // Sticky resync flag, cleared together with the overrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
    end else if (resync_s) begin
      frame_err_q <= 1'b1;
    end else if (clr_ovr) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_q;
    end
  end

  assign rx_frame_err = frame_err_q;
`else
  logic unused_resync_s;
  assign unused_resync_s = resync_s;
`endif

  assign rx_d       = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_full    = !empty_s;
  assign rx_count   = count_s;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Self-checking bench for ssp_rx_fifo: MSB-first instance checked against a queue model,
// plus an LSB-first instance for bit-order checking.
module tb_ssp_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i, sspclkin, sspfssin, ssprxd, do_read, clr_ovr;
  logic       do_read2;
  logic [7:0] rx_d, rx_d2;
  logic       rx_full, rx_full2, rx_overrun, rx_overrun2;
  logic [2:0] rx_count, rx_count2;
`ifdef SSP_RX_FRAME_ERR_EN
  logic       rx_frame_err, rx_frame_err2;
`endif

  int         total  = 0;
  int         passed = 0;
  logic [7:0] q[$];
  bit         m_ovr;

  ssp_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .sspclkin(sspclkin), .sspfssin(sspfssin),
    .ssprxd(ssprxd), .do_read(do_read), .clr_ovr(clr_ovr),
    .rx_d(rx_d), .rx_full(rx_full), .rx_count(rx_count), .rx_overrun(rx_overrun)
`ifdef SSP_RX_FRAME_ERR_EN
    , .rx_frame_err(rx_frame_err)
`endif
  );

  ssp_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk_i(clk_i), .rst_i(rst_i), .sspclkin(sspclkin), .sspfssin(sspfssin),
    .ssprxd(ssprxd), .do_read(do_read2), .clr_ovr(clr_ovr),
    .rx_d(rx_d2), .rx_full(rx_full2), .rx_count(rx_count2), .rx_overrun(rx_overrun2)
`ifdef SSP_RX_FRAME_ERR_EN
    , .rx_frame_err(rx_frame_err2)
`endif
  );

  always #10 clk_i = ~clk_i;

  // Reference model: bounded queue with sticky overrun.
  function automatic void m_push(input logic [7:0] w);
    if (q.size() < 4) q.push_back(w);
    else m_ovr = 1'b1;
  endfunction

  function automatic void m_pop();
    if (q.size() > 0) q.delete(0);
  endfunction

  function automatic logic [7:0] m_head();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  // All stimulus edges land on clk_i falling edges (multiples of 20 ns).
  task automatic send_bit(input logic f, input logic d);
    sspfssin = f;
    ssprxd   = d;
    sspclkin = 1'b1;
    #80;
    sspclkin = 1'b0;
    #80;
  endtask

  task automatic send_word(input logic [7:0] w, input bit lead, input bit ovl);
    if (lead) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(ovl && (i == 7), w[7-i]);
    sspfssin = 1'b0;
  endtask

  task automatic pulse_read();
    do_read = 1'b1;
    #20;
    do_read = 1'b0;
    m_pop();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #60;
    total++;
    if (rx_d !== 8'h00 || rx_full !== 1'b0 || rx_count !== 3'd0 || rx_overrun !== 1'b0)
      $display("FAIL reset_outputs: got d=%h full=%b cnt=%0d ovr=%b, want all 0", rx_d, rx_full, rx_count, rx_overrun);
    else passed++;
`ifdef SSP_RX_FRAME_ERR_EN
    total++;
    if (rx_frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", rx_frame_err);
    else passed++;
`endif
    rst_i = 1'b0;
    #20;
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, w[7-i]);
    ssprxd   = w[0];
    sspclkin = 1'b1;
    #80;
    sspclkin = 1'b0;
    #40;
    total++;
    if (rx_count !== 3'd0) $display("FAIL single_early: got cnt=%0d want 0 after 2 edges", rx_count);
    else passed++;
    #20;
    m_push(w);
    total++;
    if (rx_full !== 1'b1 || rx_d !== 8'hA5 || rx_count !== 3'd1)
      $display("FAIL single_latency: got full=%b d=%h cnt=%0d want 1 a5 1", rx_full, rx_d, rx_count);
    else passed++;
    #20;
    pulse_read();
    total++;
    if (rx_full !== 1'b0 || rx_count !== 3'd0)
      $display("FAIL single_read: got full=%b cnt=%0d want 0 0", rx_full, rx_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    send_word(8'h01, 1'b1, 1'b1); m_push(8'h01);
    send_word(8'h02, 1'b0, 1'b1); m_push(8'h02);
    send_word(8'h03, 1'b0, 1'b0); m_push(8'h03);
    total++;
    if (rx_count !== 3'd3) $display("FAIL b2b_count: got %0d want 3", rx_count);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (rx_d !== 8'(i)) $display("FAIL b2b_order: got %h want %h", rx_d, 8'(i));
      else passed++;
      pulse_read();
    end
    pulse_read();
    total++;
    if (rx_count !== 3'd0 || rx_full !== 1'b0)
      $display("FAIL empty_read: got cnt=%0d full=%b want 0 0", rx_count, rx_full);
    else passed++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) begin
      send_word(8'h10 + 8'(i), i == 0, i != 4);
      m_push(8'h10 + 8'(i));
    end
    total++;
    if (rx_count !== 3'd4 || rx_overrun !== m_ovr || m_ovr !== 1'b1)
      $display("FAIL ovr_set: got cnt=%0d ovr=%b want 4 1", rx_count, rx_overrun);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_d !== m_head() || m_head() !== 8'h10 + 8'(i))
        $display("FAIL ovr_order: got %h want %h", rx_d, 8'h10 + 8'(i));
      else passed++;
      pulse_read();
    end
    total++;
    if (rx_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", rx_overrun);
    else passed++;
    clr_ovr = 1'b1;
    #20;
    clr_ovr = 1'b0;
    m_ovr   = 1'b0;
    total++;
    if (rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", rx_overrun);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      send_word(w, 1'b1, 1'b0);
      m_push(w);
    end
    w = 8'h55;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, w[7-i]);
    ssprxd   = w[0];
    sspclkin = 1'b1;
    #80;
    sspclkin = 1'b0;
    #40;
    do_read = 1'b1;
    #20;
    do_read = 1'b0;
    m_pop();
    m_push(w);
    #20;
    total++;
    if (rx_count !== 3'd4 || rx_overrun !== 1'b0)
      $display("FAIL full_pushpop: got cnt=%0d ovr=%b want 4 0", rx_count, rx_overrun);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_d !== m_head()) $display("FAIL full_pushpop_data: got %h want %h", rx_d, m_head());
      else passed++;
      pulse_read();
    end
  endtask

  task automatic test_resync();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    send_word(8'h3C, 1'b1, 1'b0);
    m_push(8'h3C);
    total++;
    if (rx_count !== 3'd1 || rx_d !== 8'h3C)
      $display("FAIL resync: got cnt=%0d d=%h want 1 3c", rx_count, rx_d);
    else passed++;
`ifdef SSP_RX_FRAME_ERR_EN
    total++;
    if (rx_frame_err !== 1'b1) $display("FAIL frame_err_set: got %b want 1", rx_frame_err);
    else passed++;
    clr_ovr = 1'b1;
    #20;
    clr_ovr = 1'b0;
    total++;
    if (rx_frame_err !== 1'b0) $display("FAIL frame_err_clear: got %b want 0", rx_frame_err);
    else passed++;
`endif
    pulse_read();
  endtask

  task automatic test_random();
    int n, r;
    logic [7:0] w;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        w = 8'($urandom);
        send_word(w, k == 0, k != n - 1);
        m_push(w);
      end
      total++;
      if (rx_count !== 3'(q.size()) || rx_overrun !== m_ovr || rx_d !== m_head())
        $display("FAIL random_fill: got cnt=%0d ovr=%b d=%h want %0d %b %h",
                 rx_count, rx_overrun, rx_d, q.size(), m_ovr, m_head());
      else passed++;
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) begin
        pulse_read();
        total++;
        if (rx_count !== 3'(q.size()) || (q.size() > 0 && rx_d !== m_head()))
          $display("FAIL random_read: got cnt=%0d d=%h want %0d %h", rx_count, rx_d, q.size(), m_head());
        else passed++;
      end
      if (m_ovr) begin
        clr_ovr = 1'b1;
        #20;
        clr_ovr = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midframe_lsb();
    logic [7:0] w;
    w = 8'hA5;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    rst_i = 1'b1;
    #40;
    q.delete();
    m_ovr = 1'b0;
    total++;
    if (rx_d !== 8'h00 || rx_full !== 1'b0 || rx_count !== 3'd0 || rx_overrun !== 1'b0 ||
        rx_d2 !== 8'h00 || rx_full2 !== 1'b0 || rx_count2 !== 3'd0 || rx_overrun2 !== 1'b0)
      $display("FAIL midframe_reset: got d=%h/%h cnt=%0d/%0d ovr=%b/%b want all 0",
               rx_d, rx_d2, rx_count, rx_count2, rx_overrun, rx_overrun2);
    else passed++;
    rst_i = 1'b0;
    #20;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, w[i]);
    sspfssin = 1'b0;
    total++;
    if (rx_d2 !== 8'hA5 || rx_count2 !== 3'd1)
      $display("FAIL lsb_first: got d=%h cnt=%0d want a5 1", rx_d2, rx_count2);
    else passed++;
    total++;
    if (rx_d !== 8'hA5 || rx_count !== 3'd1)
      $display("FAIL post_reset_msb: got d=%h cnt=%0d want a5 1", rx_d, rx_count);
    else passed++;
  endtask

  initial begin
    sspclkin = 1'b0; sspfssin = 1'b0; ssprxd = 1'b0;
    do_read = 1'b0; do_read2 = 1'b0; clr_ovr = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_full_push_pop();
    test_resync();
    test_random();
    test_reset_midframe_lsb();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1);
  end

endmodule
